// File: rtl/proc_bus_master_if.sv
// rtl/proc_bus_master_if.sv - core-side request/response handshake for proc_bus_master
interface proc_bus_master_if #(
  parameter int DATA_W = 16,
  parameter int BURST  = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_rw;
  logic [DATA_W-1:0]         req_addr;
  logic [DATA_W*BURST-1:0]   req_wdata;
  logic                      resp_valid;
  logic                      resp_rw;
  logic [DATA_W*BURST-1:0]   resp_rdata;

  // master = the core issuing bursts, slave = the bus interface unit
  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rw, resp_rdata
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rw, resp_rdata
  );
endinterface

// File: rtl/proc_bus_master.sv
// rtl/proc_bus_master.sv - burst bus master on a multiplexed AddrData/AddrValid/rw bus
module proc_bus_master #(
  parameter int DATA_W      = 16,
  parameter int BURST       = 4,
  parameter int TURN_CYCLES = 1,
  parameter int IDLE_GAP    = 1
) (
  input  logic               clk,
  input  logic               resetH,
  proc_bus_master_if.slave   core,
  inout  wire [DATA_W-1:0]   AddrData,
  output logic               AddrValid,
  output logic               rw
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_TURN = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam int CNT_W = 8;
  localparam int RW_W  = DATA_W * BURST;
  localparam int RB_W  = DATA_W * (BURST - 1);

  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] addr_q;
  logic [RW_W-1:0]   wdata_q;
  logic [RB_W-1:0]   rbuf;
  logic [RW_W-1:0]   rnext;
  logic [DATA_W-1:0] drive_val;
  logic              drive_en;
  logic              accept;

  assign core.req_ready = (state == ST_IDLE) && !resetH;
  assign accept         = core.req_valid && core.req_ready;
  assign AddrValid      = (state == ST_ADDR);

  // Only the address cycle and write beats own the bus; everything else leaves it to the slave.
  assign drive_en  = (state == ST_ADDR) || ((state == ST_DATA) && !rw);
  assign drive_val = (state == ST_ADDR) ? addr_q : wdata_q[DATA_W-1:0];
  assign AddrData  = drive_en ? drive_val : {DATA_W{1'bz}};

  // Read words shift in from the top so word 0 ends up in the LSBs after the last beat.
  assign rnext = {AddrData, rbuf};

  always_ff @(posedge clk) begin
    if (resetH) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      rw              <= 1'b1;
      addr_q          <= '0;
      wdata_q         <= '0;
      rbuf            <= '0;
      core.resp_valid <= 1'b0;
      core.resp_rw    <= 1'b0;
      core.resp_rdata <= '0;
    end else begin
      core.resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rw      <= core.req_rw;
            addr_q  <= core.req_addr;
            wdata_q <= core.req_wdata;
            cnt     <= '0;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          cnt   <= '0;
          state <= ST_TURN;
        end
        ST_TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= '0;
            state <= ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rw) begin
            rbuf <= rnext[RW_W-1:DATA_W];
          end else begin
            wdata_q <= wdata_q >> DATA_W;
          end
          if (cnt == BURST_LAST) begin
            cnt             <= '0;
            state           <= ST_GAP;
            core.resp_valid <= 1'b1;
            core.resp_rw    <= rw;
            if (rw) begin
              core.resp_rdata <= rnext;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_proc_bus_master.sv
// tb/tb_proc_bus_master.sv - directed table-driven bench for proc_bus_master
module tb_proc_bus_master;
  logic clk;
  logic resetH;
  logic tb_en;
  logic [15:0] tb_val;
  wire  [15:0] bus;
  wire  [15:0] bus2;
  logic addr_valid, rw_o, addr_valid2, rw_o2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [63:0] words;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  proc_bus_master_if #(.DATA_W(16), .BURST(4)) cif ();
  proc_bus_master_if #(.DATA_W(16), .BURST(4)) cif2 ();

  proc_bus_master #(.DATA_W(16), .BURST(4), .TURN_CYCLES(1), .IDLE_GAP(1)) dut (
    .clk(clk), .resetH(resetH), .core(cif), .AddrData(bus), .AddrValid(addr_valid), .rw(rw_o)
  );

  proc_bus_master #(.DATA_W(16), .BURST(4), .TURN_CYCLES(2), .IDLE_GAP(3)) dut2 (
    .clk(clk), .resetH(resetH), .core(cif2), .AddrData(bus2), .AddrValid(addr_valid2), .rw(rw_o2)
  );

  // Bench-side slave: drives 0 when the master should be released, slave words on read beats.
  assign bus = tb_en ? tb_val : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] w;
    cif.req_valid = 1'b1;
    cif.req_rw    = v.rw;
    cif.req_addr  = v.addr;
    cif.req_wdata = v.words;
    cyc();
    for (int c = 1; c <= 8; c++) begin
      w = 16'h0000;
      if (c >= 3 && c <= 6) w = v.words[16*(c-3) +: 16];
      tb_en  = !(c == 1 || (!v.rw && c >= 3 && c <= 6));
      tb_val = v.rw ? w : 16'h0000;
      #3;
      chk($sformatf("v%0d c%0d addr_valid", idx, c), 64'(addr_valid), 64'(c == 1));
      chk($sformatf("v%0d c%0d rw", idx, c), 64'(rw_o), 64'(v.rw));
      chk($sformatf("v%0d c%0d req_ready", idx, c), 64'(cif.req_ready), 64'(c == 8));
      chk($sformatf("v%0d c%0d resp_valid", idx, c), 64'(cif.resp_valid), 64'(c == 7));
      chk($sformatf("v%0d c%0d bus", idx, c), 64'(bus), (c == 1) ? 64'(v.addr) : 64'(w));
      if (c >= 7) begin
        chk($sformatf("v%0d c%0d resp_rdata", idx, c), cif.resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d c%0d resp_rw", idx, c), 64'(cif.resp_rw), 64'(v.rw));
      end
      // Busy-time request noise must be ignored.
      cif.req_valid = (c < 7);
      cif.req_rw    = ~v.rw;
      cif.req_addr  = v.addr ^ 16'(c * 16'h1111);
      cif.req_wdata = ~v.words;
      if (c < 8) cyc();
    end
    tb_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{rw: 1'b0, addr: 16'h2000, words: 64'h9ABC_5678_1234_ABCD, exp_rdata: 64'h0};
    vecs[1] = '{rw: 1'b1, addr: 16'h2000, words: 64'h9ABC_5678_1234_ABCD, exp_rdata: 64'h9ABC_5678_1234_ABCD};
    vecs[2] = '{rw: 1'b0, addr: 16'hFFFF, words: 64'h8000_0001_FFFF_0000, exp_rdata: 64'h9ABC_5678_1234_ABCD};
    vecs[3] = '{rw: 1'b1, addr: 16'h0004, words: 64'h5A5A_A5A5_0000_FFFF, exp_rdata: 64'h5A5A_A5A5_0000_FFFF};

    tb_en = 1'b0; tb_val = 16'h0;
    cif.req_valid = 1'b1; cif.req_rw = 1'b0; cif.req_addr = 16'h1234; cif.req_wdata = 64'h1;
    cif2.req_valid = 1'b0; cif2.req_rw = 1'b0; cif2.req_addr = 16'h0; cif2.req_wdata = 64'h0;
    resetH = 1'b1;
    cyc(); cyc();
    #3;
    chk("rst req_ready", 64'(cif.req_ready), 64'h0);
    chk("rst addr_valid", 64'(addr_valid), 64'h0);
    chk("rst rw", 64'(rw_o), 64'h1);
    chk("rst resp_valid", 64'(cif.resp_valid), 64'h0);
    chk("rst resp_rw", 64'(cif.resp_rw), 64'h0);
    chk("rst resp_rdata", cif.resp_rdata, 64'h0);
    resetH = 1'b0;
    cif.req_valid = 1'b0;
    cyc();
    #3;
    chk("post-rst req_ready", 64'(cif.req_ready), 64'h1);
    chk("post-rst no accept", 64'(addr_valid), 64'h0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Back-to-back: req_valid held high across two requests.
    cif.req_valid = 1'b1; cif.req_rw = 1'b0; cif.req_addr = 16'h1111;
    cif.req_wdata = 64'h4444_3333_2222_1111;
    cyc();
    for (int c = 1; c <= 16; c++) begin
      #3;
      chk($sformatf("b2b c%0d addr_valid", c), 64'(addr_valid), 64'(c == 1 || c == 9));
      chk($sformatf("b2b c%0d req_ready", c), 64'(cif.req_ready), 64'(c == 8 || c == 16));
      chk($sformatf("b2b c%0d resp_valid", c), 64'(cif.resp_valid), 64'(c == 7 || c == 15));
      if (c >= 9) cif.req_valid = 1'b0;
      if (c < 16) cyc();
    end

    // TURN_CYCLES=2, IDLE_GAP=3 build with req_valid held.
    cif2.req_valid = 1'b1; cif2.req_rw = 1'b0; cif2.req_addr = 16'h4000;
    cif2.req_wdata = 64'h0004_0003_0002_0001;
    cyc();
    for (int c = 1; c <= 12; c++) begin
      #3;
      chk($sformatf("p2 c%0d addr_valid", c), 64'(addr_valid2), 64'(c == 1 || c == 12));
      chk($sformatf("p2 c%0d resp_valid", c), 64'(cif2.resp_valid), 64'(c == 8));
      chk($sformatf("p2 c%0d req_ready", c), 64'(cif2.req_ready), 64'(c == 11));
      if (c >= 4 && c <= 7) chk($sformatf("p2 c%0d bus", c), 64'(bus2), 64'(c - 3));
      if (c == 1) chk("p2 addr", 64'(bus2), 64'h4000);
      if (c == 12) cif2.req_valid = 1'b0;
      cyc();
    end
    for (int c = 13; c <= 23; c++) cyc();
    #3;
    chk("p2 idle ready", 64'(cif2.req_ready), 64'h1);

    // Reset during read beat 1.
    cif.req_valid = 1'b1; cif.req_rw = 1'b1; cif.req_addr = 16'h3000;
    cyc();
    cif.req_valid = 1'b0;
    #3;
    chk("ab addr_valid", 64'(addr_valid), 64'h1);
    cyc();
    tb_en = 1'b1; tb_val = 16'h0;
    cyc();
    tb_val = 16'h1111;
    cyc();
    tb_val = 16'h2222;
    #3;
    resetH = 1'b1;
    cyc();
    tb_val = 16'h0;
    #3;
    chk("ab addr_valid after", 64'(addr_valid), 64'h0);
    chk("ab bus released", 64'(bus), 64'h0);
    chk("ab resp_rdata", cif.resp_rdata, 64'h0);
    chk("ab ready in rst", 64'(cif.req_ready), 64'h0);
    chk("ab rw", 64'(rw_o), 64'h1);
    resetH = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      #3;
      chk($sformatf("ab c%0d resp_valid", c), 64'(cif.resp_valid), 64'h0);
      chk($sformatf("ab c%0d bus", c), 64'(bus), 64'h0);
      if (c == 0) chk("ab ready after", 64'(cif.req_ready), 64'h1);
    end
    tb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
